// File: rtl/fsic_wb2axil_bridge_pkg.sv
// Shared types and defaults for the FSIC Wishbone-to-AXI-Lite bridge.
package fsic_wb2axil_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    ACK     = 3'd5
  } state_e;

  localparam logic [31:0] DEF_ADDR_BASE = 32'h3000_0000;
  localparam logic [31:0] DEF_ADDR_MASK = 32'hFFF0_0000;
  localparam logic [31:0] DEF_TO_RDATA  = 32'hDEAD_BEEF;
  localparam int          WDT_W         = 8;

  function automatic logic in_window(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (adr & mask) == base;
  endfunction

endpackage

// File: rtl/fsic_wb2axil_bridge_wdt_cnt.sv
// Watchdog counter: counts wait cycles of one bridge transaction and pulses
// expire on the TIMEOUT-th wait cycle.
module fsic_wdt_cnt
  import fsic_wb2axil_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [WDT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + WDT_W'(1);
  end

  // cnt holds completed wait cycles, so the current cycle is wait cycle cnt+1.
  assign expire = en && (cnt == WDT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fsic_wb2axil_bridge.sv
// Wishbone-classic slave that turns each in-window cycle into one AXI-Lite
// master transaction, with a watchdog so a hung slave never stalls the WB bus.
module fsic_wb2axil_bridge
  import fsic_wb2axil_bridge_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = DEF_ADDR_BASE,
  parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK,
  parameter int          AXI_AW    = 15,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] TO_RDATA  = DEF_TO_RDATA
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  input  logic [31:0]       wbs_adr,
  input  logic [31:0]       wbs_wdata,
  input  logic [3:0]        wbs_sel,
  input  logic              wbs_cyc,
  input  logic              wbs_stb,
  input  logic              wbs_we,
  output logic              wbs_ack,
  output logic [31:0]       wbs_rdata,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [AXI_AW-1:0] m_awaddr,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [AXI_AW-1:0] m_araddr,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [31:0]       m_rdata,
  output logic              err_timeout
);

  state_e            state_q, state_d;
  logic [AXI_AW-1:0] adr_q, adr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        sel_q, sel_d;
  logic              we_q, we_d;
  logic              awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic              ack_d, err_d;
  logic [31:0]       rdata_d;
  logic              wb_sel, expire;

  assign wb_sel   = wbs_cyc && wbs_stb && in_window(wbs_adr, ADDR_BASE, ADDR_MASK);
  assign m_awaddr = adr_q;
  assign m_araddr = adr_q;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = sel_q;

  fsic_wdt_cnt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk    (wb_clk),
    .rst    (wb_rst),
    .clr    (state_q == IDLE),
    .en     ((state_q != IDLE) && (state_q != ACK)),
    .expire (expire)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d   = state_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    we_d      = we_q;
    awvalid_d = m_awvalid;
    wvalid_d  = m_wvalid;
    bready_d  = m_bready;
    arvalid_d = m_arvalid;
    rready_d  = m_rready;
    ack_d     = 1'b0;
    rdata_d   = wbs_rdata;
    err_d     = err_timeout;

    unique case (state_q)
      IDLE: if (wb_sel) begin
        adr_d   = wbs_adr[AXI_AW-1:0];
        wdata_d = wbs_wdata;
        sel_d   = wbs_sel;
        we_d    = wbs_we;
        if (wbs_we) begin
          state_d   = WR_REQ;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else begin
          state_d   = RD_REQ;
          arvalid_d = 1'b1;
        end
      end
      WR_REQ: begin
        // A channel whose valid is already low has completed its handshake.
        awvalid_d = m_awvalid && !m_awready;
        wvalid_d  = m_wvalid && !m_wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: if (m_bvalid) begin
        state_d  = ACK;
        bready_d = 1'b0;
        ack_d    = 1'b1;
        rdata_d  = '0;
      end
      RD_REQ: if (m_arready) begin
        state_d   = RD_RESP;
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
      end
      RD_RESP: if (m_rvalid) begin
        state_d  = ACK;
        rready_d = 1'b0;
        ack_d    = 1'b1;
        rdata_d  = m_rdata;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A response arriving in the expiry cycle still completes normally.
    if (expire && (state_d != ACK)) begin
      state_d   = ACK;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      ack_d     = 1'b1;
      err_d     = 1'b1;
      rdata_d   = we_q ? 32'h0 : TO_RDATA;
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      m_awvalid   <= 1'b0;
      m_wvalid    <= 1'b0;
      m_bready    <= 1'b0;
      m_arvalid   <= 1'b0;
      m_rready    <= 1'b0;
      wbs_ack     <= 1'b0;
      wbs_rdata   <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      m_awvalid   <= awvalid_d;
      m_wvalid    <= wvalid_d;
      m_bready    <= bready_d;
      m_arvalid   <= arvalid_d;
      m_rready    <= rready_d;
      wbs_ack     <= ack_d;
      wbs_rdata   <= rdata_d;
      err_timeout <= err_d;
    end
  end

endmodule
